mac_pipe: RTL and testbench
===========================

# mac_pipe

Parametrised, pipelined, saturating multiply-accumulate unit for the SNN datapath. It computes one dot product of LEN signed term pairs, `a`×`b`, arriving under a valid strobe. It reports the result with a one-cycle done pulse and holds sticky overflow/underflow flags. It is the successor to the single-cycle accumulator used in the neuron layers and adds configurable widths, a registered product stage, an optional saturating mode and term counting.

## Interface
- IN_W, default 8: signed operand width.
- ACC_W, default 16: signed accumulator width. ACC_W >= 2*IN_W is required; elaboration fails otherwise.
- LEN, default 784: number of terms per dot product. LEN >= 1.
- SAT, default 1: overflow mode. 1 means clamp to max/min; 0 means two's-complement wrap.

- clk, input, 1: system clock (50 MHz).
- rst_n, input, 1: asynchronous, active-low reset.
- clr_n, input, 1: synchronous, active-low clear of the whole block.
- in_vld, input, 1: `a`/`b` hold a valid term this cycle.
- a, input, IN_W: signed operand 1.
- b, input, IN_W: signed operand 2.
- acc, output, ACC_W: signed accumulated value (registered).
- acc_vld, output, 1: one-cycle pulse; `acc` holds the completed LEN-term result.
- of, output, 1: sticky overflow flag for the current dot product.
- uf, output, 1: sticky underflow flag for the current dot product.
- busy, output, 1: a dot product is in progress. Asserted when count != 0 or prod_vld = 1.

## Operation
- Stage 1 (product):
  - On `in_vld`, register `prod` = signed `a`×`b` (2*IN_W bits) and set `prod_vld`.
  - Otherwise clear `prod_vld`.
- Stage 2 (accumulate), active when `prod_vld` = 1:
  - Sign-extend `prod` to ACC_W+1 bits.
  - Add `base`, sign-extended to ACC_W+1 bits. `base` = 0 if count == 0, else `acc`.
  - Let `sum` be the ACC_W+1-bit result.
- Overflow detection on `sum[ACC_W:ACC_W-1]`:
  - 01: overflow.
  - 10: underflow.
  - Otherwise the result is `sum[ACC_W-1:0]`.
- Result on overflow/underflow:
  - SAT=1: overflow gives max (0x7FFF for 16 bits), underflow gives min (0x8000).
  - SAT=0: low ACC_W bits (wrap).
- Flag update:
  - When count == 0, the first accumulation loads `of`/`uf` from this term's detection. Old flags are discarded.
  - Otherwise the new detection is ORed into the flags (sticky).
- Term counter: width $clog2(LEN), or 1 if LEN == 1. It increments on each stage-2 accumulation.
  - At LEN-1 it wraps to 0 and `acc_vld` pulses on the same edge that writes the final `acc`.
- After completion:
  - `acc`, `of` and `uf` hold until the next accumulation.
  - The next accumulation starts a fresh dot product (base 0).
- Bubbles: `in_vld` gaps do not advance the counter. `acc` holds.
- clr_n low at a clock edge:
  - `acc`, count, `prod_vld`, `acc_vld`, `of` and `uf` go to 0.
  - The in-flight product is discarded.
  - `in_vld` on the same edge is ignored. Clear has priority over everything.
- Back-to-back dot products: `in_vld` may stay high continuously across the LEN boundary. No dead cycle is required.

## Timing
- Reset values (rst_n low, asynchronous): `acc`=0, `acc_vld`=0, `of`=0, `uf`=0, `busy`=0. Internal `prod`=0, `prod_vld`=0, count=0.
- Latency:
  - Term sampled at edge n: product registered at edge n.
  - `acc` updated at edge n+1.
- Done pulse: the last term sampled at edge n gives `acc_vld` high from edge n+1 to edge n+2 only.
- Throughput: one term per cycle.
- Flags change only on accumulation edges, clear or reset.
- rst_n asserted mid-operation aborts immediately. No partial result or pulse is emitted.

## Test plan
1. IN_W=8, ACC_W=16, LEN=4, SAT=1; a=3, b=4 for 4 consecutive cycles -> `acc` 12, 24, 36, 48 on successive edges; `acc_vld` high for exactly one cycle with `acc`=48; of=uf=0; `busy` low afterwards.
2. Overflow: a=127, b=127 ×3, then a=0 ×1.
   - SAT=1 -> `acc` 16129, 32258, 32767, 32767; of=1 held through `acc_vld`.
   - SAT=0 -> third value 0xBD03 (-17149), of=1.
3. Underflow: a=-128, b=127 ×3, then a=0 ×1, SAT=1 -> `acc` -16256, -32512, -32768, -32768; uf=1, of=0. Next dot product with a=1, b=1 ×4 -> `acc`=4, uf=0.
4. Bubbles: 4 terms of a=2, b=-5 with `in_vld` gaps of 1 to 3 cycles -> `acc`=-40 and one `acc_vld` pulse, aligned to the last term +1 edge; no pulse before that.
5. Clear: 2 terms of a=10, b=10 accumulated, then clr_n low for one cycle while `in_vld`=1 with a=9, b=9 -> `acc`=0 and count=0, the 81 term is dropped. Then 4 terms of a=1, b=1 -> `acc`=4 with `acc_vld`.
6. Reset and back-to-back:
   - rst_n pulsed low mid-product -> all outputs 0 immediately; no `acc_vld`.
   - Then 8 continuous terms of a=1, b=1 -> two `acc_vld` pulses 4 cycles apart, each with `acc`=4.

Source files
------------

// File: rtl/mac_pipe.sv
// Pipelined signed multiply-accumulate over LEN-term dot products. The product
// stage is registered, and the accumulator optionally saturates with sticky of/uf flags.
module mac_pipe #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16,
  parameter int LEN   = 784,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             in_vld,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] acc,
  output logic             acc_vld,
  output logic             of,
  output logic             uf,
  output logic             busy
);

  localparam int P_W   = 2 * IN_W;
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < 2 * IN_W) begin : g_bad_acc_w
    $error("mac_pipe: ACC_W must be at least 2*IN_W");
  end
  if (LEN < 1) begin : g_bad_len
    $error("mac_pipe: LEN must be at least 1");
  end

  logic [P_W-1:0]   prod_q, prod_d;
  logic             prod_vld_q, prod_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_vld_q, acc_vld_d;
  logic             of_q, of_d;
  logic             uf_q, uf_d;

  logic [ACC_W:0]   prod_ext, base, sum;
  logic             ovf, unf, first;

  // One guard bit above the accumulator exposes overflow in the top two sum bits.
  always_comb begin
    first    = (cnt_q == '0);
    prod_ext = {{(ACC_W+1-P_W){prod_q[P_W-1]}}, prod_q};
    base     = first ? '0 : {acc_q[ACC_W-1], acc_q};
    sum      = prod_ext + base;
    ovf      = (sum[ACC_W:ACC_W-1] == 2'b01);
    unf      = (sum[ACC_W:ACC_W-1] == 2'b10);
  end

  always_comb begin
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    acc_vld_d  = 1'b0;
    of_d       = of_q;
    uf_d       = uf_q;
    if (!clr_n) begin
      prod_d = '0;
      cnt_d  = '0;
      acc_d  = '0;
      of_d   = 1'b0;
      uf_d   = 1'b0;
    end else begin
      prod_vld_d = in_vld;
      if (in_vld) begin
        prod_d = P_W'($signed(a)) * P_W'($signed(b));
      end
      if (prod_vld_q) begin
        if (SAT != 0 && ovf) begin
          acc_d = ACC_MAX;
        end else if (SAT != 0 && unf) begin
          acc_d = ACC_MIN;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        of_d = first ? ovf : (of_q | ovf);
        uf_d = first ? unf : (uf_q | unf);
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          acc_vld_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      acc_vld_q  <= 1'b0;
      of_q       <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      acc_vld_q  <= acc_vld_d;
      of_q       <= of_d;
      uf_q       <= uf_d;
    end
  end

  assign acc     = acc_q;
  assign acc_vld = acc_vld_q;
  assign of      = of_q;
  assign uf      = uf_q;
  assign busy    = (cnt_q != '0) || prod_vld_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench for mac_pipe: saturating and wrapping instances (LEN=4) share one
// stimulus stream, and every done pulse is checked against a queued expected result.
module tb_mac_pipe;

  logic        clk;
  logic        rst_n;
  logic        clr_n;
  logic        in_vld;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] acc_s, acc_w;
  logic        acc_vld_s, acc_vld_w;
  logic        of_s, of_w, uf_s, uf_w, busy_s, busy_w;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int acc_s;
    int acc_w;
    bit of;
    bit uf;
  } exp_t;
  exp_t sb[$];

  mac_pipe #(.IN_W(8), .ACC_W(16), .LEN(4), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .a(a), .b(b),
    .acc(acc_s), .acc_vld(acc_vld_s), .of(of_s), .uf(uf_s), .busy(busy_s)
  );

  mac_pipe #(.IN_W(8), .ACC_W(16), .LEN(4), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .a(a), .b(b),
    .acc(acc_w), .acc_vld(acc_vld_w), .of(of_w), .uf(uf_w), .busy(busy_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic term(input int ta, input int tb);
    in_vld = 1'b1;
    a      = 8'(ta);
    b      = 8'(tb);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    a      = '0;
    b      = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int es, input int ew, input bit eof, input bit euf);
    exp_t e;
    e.acc_s = es;
    e.acc_w = ew;
    e.of    = eof;
    e.uf    = euf;
    sb.push_back(e);
  endtask

  task automatic chk_acc(input string name, input int es, input int ew);
    check({name, "_sat"}, $signed(acc_s), es);
    check({name, "_wrap"}, $signed(acc_w), ew);
  endtask

  // Three terms of (ta,tb), a fourth of (ta3,tb); running acc checked after each edge.
  task automatic run4(input string name, input int ta, input int tb, input int ta3,
                      input int es0, input int es1, input int es2, input int es3,
                      input int ew0, input int ew1, input int ew2, input int ew3,
                      input bit eof, input bit euf);
    term(ta, tb);
    term(ta, tb);
    chk_acc({name, "_acc0"}, es0, ew0);
    term(ta, tb);
    chk_acc({name, "_acc1"}, es1, ew1);
    push(es3, ew3, eof, euf);
    term(ta3, tb);
    chk_acc({name, "_acc2"}, es2, ew2);
    idle(1);
    chk_acc({name, "_acc3"}, es3, ew3);
  endtask

  always @(negedge clk) begin
    if (rst_n && (acc_vld_s || acc_vld_w)) begin
      if (sb.size() == 0) begin
        check("unexpected_acc_vld", {31'd0, acc_vld_s | acc_vld_w}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_vld_sat", {31'd0, acc_vld_s}, 1);
        check("mon_vld_wrap", {31'd0, acc_vld_w}, 1);
        check("mon_acc_sat", $signed(acc_s), e.acc_s);
        check("mon_acc_wrap", $signed(acc_w), e.acc_w);
        check("mon_of_sat", {31'd0, of_s}, {31'd0, e.of});
        check("mon_uf_sat", {31'd0, uf_s}, {31'd0, e.uf});
        check("mon_of_wrap", {31'd0, of_w}, {31'd0, e.of});
        check("mon_uf_wrap", {31'd0, uf_w}, {31'd0, e.uf});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    clr_n  = 1'b1;
    in_vld = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", $signed(acc_s), 0);
    check("rst_acc_vld", {31'd0, acc_vld_s}, 0);
    check("rst_of", {31'd0, of_s}, 0);
    check("rst_uf", {31'd0, uf_s}, 0);
    check("rst_busy", {31'd0, busy_s}, 0);
    rst_n = 1'b1;
    idle(1);

    // Basic 3*4 x4
    run4("basic", 3, 4, 3, 12, 24, 36, 48, 12, 24, 36, 48, 1'b0, 1'b0);
    check("basic_busy_after", {31'd0, busy_s}, 0);
    idle(1);

    // Overflow: saturating clamps, wrapping keeps 0xBD03
    run4("ovf", 127, 127, 0, 16129, 32258, 32767, 32767,
         16129, 32258, -17149, -17149, 1'b1, 1'b0);
    idle(1);

    // Underflow, then a fresh dot product clears the flags
    run4("unf", -128, 127, 0, -16256, -32512, -32768, -32768,
         -16256, -32512, 16768, 16768, 1'b0, 1'b1);
    run4("fresh", 1, 1, 1, 1, 2, 3, 4, 1, 2, 3, 4, 1'b0, 1'b0);
    idle(1);

    // Bubbles between terms
    term(2, -5);
    idle(1);
    term(2, -5);
    idle(2);
    chk_acc("bubble_hold", -20, -20);
    term(2, -5);
    idle(3);
    push(-40, -40, 1'b0, 1'b0);
    term(2, -5);
    check("bubble_no_early_vld", {31'd0, acc_vld_s}, 0);
    idle(1);
    check("bubble_vld", {31'd0, acc_vld_s}, 1);
    chk_acc("bubble_acc", -40, -40);
    idle(1);

    // Clear mid-dot-product with a term presented on the same edge
    term(10, 10);
    term(10, 10);
    idle(1);
    chk_acc("clr_pre", 200, 200);
    clr_n  = 1'b0;
    in_vld = 1'b1;
    a      = 8'd9;
    b      = 8'd9;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    chk_acc("clr_acc", 0, 0);
    check("clr_busy", {31'd0, busy_s}, 0);
    idle(2);
    chk_acc("clr_dropped", 0, 0);
    check("clr_busy_after", {31'd0, busy_s}, 0);
    run4("post_clr", 1, 1, 1, 1, 2, 3, 4, 1, 2, 3, 4, 1'b0, 1'b0);
    idle(1);

    // Asynchronous reset mid-product
    term(5, 5);
    term(5, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_acc", $signed(acc_s), 0);
    check("arst_acc_vld", {31'd0, acc_vld_s}, 0);
    check("arst_of", {31'd0, of_s}, 0);
    check("arst_uf", {31'd0, uf_s}, 0);
    check("arst_busy", {31'd0, busy_s}, 0);
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check("arst_acc_after", $signed(acc_s), 0);

    // Back-to-back dot products with in_vld held high
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 7) push(4, 4, 1'b0, 1'b0);
      term(1, 1);
      if (i == 4) begin
        check("b2b_vld1", {31'd0, acc_vld_s}, 1);
        chk_acc("b2b_acc1", 4, 4);
      end
      if (i == 5) begin
        check("b2b_vld1_single", {31'd0, acc_vld_s}, 0);
        chk_acc("b2b_restart", 1, 1);
      end
    end
    idle(1);
    check("b2b_vld2", {31'd0, acc_vld_s}, 1);
    chk_acc("b2b_acc2", 4, 4);
    idle(3);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
